// File: rtl/e203_nts_ctx_pkg.sv
// Shared types and geometry helpers for the NTS context save/restore sequencer.
// Optional error flags are enabled with the E203_NTS_CTX_ERR_EN macro.
package e203_nts_ctx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SAVE = 2'd1,
        RD   = 2'd2,
        WB   = 2'd3
    } ctx_state_e;

    localparam int NREGS_DEF = 16;
    localparam int AW_DEF    = 8;

    function automatic int idx_width(input int nregs);
        return $clog2(nregs);
    endfunction

    function automatic int nframes(input int nregs, input int aw);
        return (1 << aw) / nregs;
    endfunction

    // One extra bit so a completely full stack (fp == NFRAMES) is representable
    function automatic int fp_width(input int nregs, input int aw);
        return aw - $clog2(nregs) + 1;
    endfunction

    localparam int IW_DEF      = idx_width(NREGS_DEF);
    localparam int NFRAMES_DEF = nframes(NREGS_DEF, AW_DEF);
    localparam int FPW_DEF     = fp_width(NREGS_DEF, AW_DEF);

endpackage

// File: rtl/e203_nts_ctx_fp.sv
// Frame pointer with full/empty detection and the sticky overflow/underflow flags.
// Flags exist only when E203_NTS_CTX_ERR_EN is defined; otherwise they read as 0.
module e203_nts_ctx_fp #(
    parameter int FPW     = 5,
    parameter int NFRAMES = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           fp_inc,
    input  logic           fp_dec,
    input  logic           ovf_set,
    input  logic           unf_set,
    input  logic           err_clr,
    output logic [FPW-1:0] fp,
    output logic           full,
    output logic           empty,
    output logic           ovf_err,
    output logic           unf_err
);

    localparam logic [FPW-1:0] FP_ONE  = FPW'(1);
    localparam logic [FPW-1:0] FP_ZERO = {FPW{1'b0}};
    localparam logic [FPW-1:0] FP_FULL = FPW'(NFRAMES);

    logic [FPW-1:0] fp_r;

    // Frame pointer: grows when a save completes, shrinks when a restore is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            fp_r <= FP_ZERO;
        end else if (fp_inc) begin
            fp_r <= fp_r + FP_ONE;
        end else if (fp_dec) begin
            fp_r <= fp_r - FP_ONE;
        end else begin
            fp_r <= fp_r;
        end
    end

    assign fp    = fp_r;
    assign full  = (fp_r == FP_FULL);
    assign empty = (fp_r == FP_ZERO);

`ifdef E203_NTS_CTX_ERR_EN
    logic ovf_err_r;
    logic unf_err_r;

    // Sticky flags; a new error in the same cycle as err_clr keeps the flag set
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_err_r <= 1'b0;
            unf_err_r <= 1'b0;
        end else begin
            if (ovf_set) begin
                ovf_err_r <= 1'b1;
            end else if (err_clr) begin
                ovf_err_r <= 1'b0;
            end else begin
                ovf_err_r <= ovf_err_r;
            end
            if (unf_set) begin
                unf_err_r <= 1'b1;
            end else if (err_clr) begin
                unf_err_r <= 1'b0;
            end else begin
                unf_err_r <= unf_err_r;
            end
        end
    end

    assign ovf_err = ovf_err_r;
    assign unf_err = unf_err_r;
`else
    logic unused_err_s;
    assign unused_err_s = ^{ovf_set, unf_set, err_clr};
    assign ovf_err      = 1'b0;
    assign unf_err      = 1'b0;
`endif

endmodule

// File: rtl/e203_nts_ctx_seq.sv
// Context save/restore sequencer streaming regfile frames to/from the NTS RAM stack.
// E203_NTS_CTX_ERR_EN enables the sticky ovf_err/unf_err flags and err_clr.
module e203_nts_ctx_seq #(
    parameter int NREGS = 16,
    parameter int AW    = 8,
    parameter int DW    = 32,
    parameter int MW    = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        save_req,
    input  logic                        restore_req,
    output logic                        busy,
    output logic                        done,
    output logic [$clog2(NREGS)-1:0]    rf_rd_idx,
    input  logic [DW-1:0]               rf_rd_data,
    output logic                        rf_wr_en,
    output logic [$clog2(NREGS)-1:0]    rf_wr_idx,
    output logic [DW-1:0]               rf_wr_data,
    output logic                        nts_ram_cs,
    output logic                        nts_ram_we,
    output logic [AW-1:0]               nts_ram_addr,
    output logic [MW-1:0]               nts_ram_wem,
    output logic [DW-1:0]               nts_ram_din,
    input  logic [DW-1:0]               nts_ram_dout,
    output logic [AW-$clog2(NREGS):0]   depth,
    output logic                        ovf_err,
    output logic                        unf_err,
    input  logic                        err_clr
);

    import e203_nts_ctx_pkg::*;

    localparam int IW  = idx_width(NREGS);
    localparam int FPW = fp_width(NREGS, AW);
    localparam int NFR = nframes(NREGS, AW);

    localparam logic [IW-1:0] IDX_ZERO = {IW{1'b0}};
    localparam logic [IW-1:0] IDX_ONE  = IW'(1);
    localparam logic [IW-1:0] IDX_LAST = IW'(NREGS - 1);

    ctx_state_e     state_r;
    ctx_state_e     state_nxt;
    logic [IW-1:0]  idx_r;
    logic [IW-1:0]  idx_nxt;
    logic           pending_r;
    logic           pending_nxt;
    logic           rf_wr_en_r;
    logic [IW-1:0]  rf_wr_idx_r;

    logic           fp_inc_s;
    logic           fp_dec_s;
    logic           ovf_set_s;
    logic           unf_set_s;
    logic [FPW-1:0] fp_s;
    logic           full_s;
    logic           empty_s;

    e203_nts_ctx_fp #(
        .FPW     (FPW),
        .NFRAMES (NFR)
    ) u_fp (
        .clk     (clk),
        .rst     (rst),
        .fp_inc  (fp_inc_s),
        .fp_dec  (fp_dec_s),
        .ovf_set (ovf_set_s),
        .unf_set (unf_set_s),
        .err_clr (err_clr),
        .fp      (fp_s),
        .full    (full_s),
        .empty   (empty_s),
        .ovf_err (ovf_err),
        .unf_err (unf_err)
    );

    // Sequencer state, slot index within the frame and the one-deep pending save
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            idx_r     <= IDX_ZERO;
            pending_r <= 1'b0;
        end else begin
            state_r   <= state_nxt;
            idx_r     <= idx_nxt;
            pending_r <= pending_nxt;
        end
    end

    // Write-back trails each RAM read by one cycle to match the RAM read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wr_en_r  <= 1'b0;
            rf_wr_idx_r <= IDX_ZERO;
        end else if (state_r == RD) begin
            rf_wr_en_r  <= 1'b1;
            rf_wr_idx_r <= idx_r;
        end else begin
            rf_wr_en_r  <= 1'b0;
            rf_wr_idx_r <= IDX_ZERO;
        end
    end

    // Next-state logic; save has priority, and requests that cannot run are dropped
    always_comb begin
        state_nxt   = state_r;
        idx_nxt     = idx_r;
        pending_nxt = pending_r;
        fp_inc_s    = 1'b0;
        fp_dec_s    = 1'b0;
        ovf_set_s   = 1'b0;
        unf_set_s   = 1'b0;
        case (state_r)
            IDLE: begin
                idx_nxt = IDX_ZERO;
                if (save_req) begin
                    if (full_s) begin
                        ovf_set_s = 1'b1;
                    end else begin
                        state_nxt = SAVE;
                    end
                end else if (restore_req) begin
                    if (empty_s) begin
                        unf_set_s = 1'b1;
                    end else begin
                        state_nxt = RD;
                        fp_dec_s  = 1'b1;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            SAVE: begin
                if (idx_r == IDX_LAST) begin
                    state_nxt = IDLE;
                    idx_nxt   = IDX_ZERO;
                    fp_inc_s  = 1'b1;
                end else begin
                    idx_nxt   = idx_r + IDX_ONE;
                end
            end
            RD: begin
                if (save_req) begin
                    pending_nxt = 1'b1;
                end else begin
                    pending_nxt = pending_r;
                end
                if (idx_r == IDX_LAST) begin
                    state_nxt = WB;
                    idx_nxt   = IDX_ZERO;
                end else begin
                    idx_nxt   = idx_r + IDX_ONE;
                end
            end
            WB: begin
                idx_nxt     = IDX_ZERO;
                pending_nxt = 1'b0;
                if (save_req || pending_r) begin
                    if (full_s) begin
                        state_nxt = IDLE;
                        ovf_set_s = 1'b1;
                    end else begin
                        state_nxt = SAVE;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt   = IDLE;
                idx_nxt     = IDX_ZERO;
                pending_nxt = 1'b0;
            end
        endcase
    end

    // Output decode purely from registered state; signals not owned by a state stay 0
    always_comb begin
        busy         = 1'b0;
        done         = 1'b0;
        rf_rd_idx    = IDX_ZERO;
        nts_ram_cs   = 1'b0;
        nts_ram_we   = 1'b0;
        nts_ram_wem  = {MW{1'b0}};
        nts_ram_addr = {AW{1'b0}};
        nts_ram_din  = {DW{1'b0}};
        case (state_r)
            SAVE: begin
                busy         = 1'b1;
                done         = (idx_r == IDX_LAST);
                rf_rd_idx    = idx_r;
                nts_ram_cs   = 1'b1;
                nts_ram_we   = 1'b1;
                nts_ram_wem  = {MW{1'b1}};
                nts_ram_addr = {fp_s[FPW-2:0], idx_r};
                nts_ram_din  = rf_rd_data;
            end
            RD: begin
                busy         = 1'b1;
                nts_ram_cs   = 1'b1;
                nts_ram_addr = {fp_s[FPW-2:0], idx_r};
            end
            WB: begin
                busy         = 1'b1;
                done         = 1'b1;
            end
            default: begin
                busy         = 1'b0;
            end
        endcase
    end

    assign rf_wr_en   = rf_wr_en_r;
    assign rf_wr_idx  = rf_wr_idx_r;
    assign rf_wr_data = rf_wr_en_r ? nts_ram_dout : {DW{1'b0}};
    assign depth      = fp_s;

endmodule

// File: tb/tb_e203_nts_ctx_seq.sv
// Self-checking bench for e203_nts_ctx_seq: directed steps plus a random save/restore
// phase, checked against a LIFO-of-words reference model. Honours E203_NTS_CTX_ERR_EN.
module tb_e203_nts_ctx_seq;

    localparam int NREGS = 16;
    localparam int AW    = 8;
    localparam int DW    = 32;
    localparam int MW    = 4;
    localparam int IW    = 4;
    localparam int FPW   = 5;
    localparam int NFR   = 16;
`ifdef E203_NTS_CTX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           save_req = 1'b0;
    logic           restore_req = 1'b0;
    logic           err_clr = 1'b0;
    logic           busy, done, rf_wr_en, nts_ram_cs, nts_ram_we, ovf_err, unf_err;
    logic [IW-1:0]  rf_rd_idx, rf_wr_idx;
    logic [DW-1:0]  rf_rd_data, rf_wr_data, nts_ram_din, ram_dout;
    logic [AW-1:0]  nts_ram_addr;
    logic [MW-1:0]  nts_ram_wem;
    logic [FPW-1:0] depth;

    logic [DW-1:0]  rf [NREGS];
    logic [DW-1:0]  mem [1 << AW];
    logic [DW-1:0]  stack_q [$];
    bit             exp_ovf, exp_unf;
    int             n_checks = 0;
    int             n_fail = 0;

    e203_nts_ctx_seq #(.NREGS(NREGS), .AW(AW), .DW(DW), .MW(MW)) dut (
        .clk(clk), .rst(rst), .save_req(save_req), .restore_req(restore_req),
        .busy(busy), .done(done), .rf_rd_idx(rf_rd_idx), .rf_rd_data(rf_rd_data),
        .rf_wr_en(rf_wr_en), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
        .nts_ram_cs(nts_ram_cs), .nts_ram_we(nts_ram_we), .nts_ram_addr(nts_ram_addr),
        .nts_ram_wem(nts_ram_wem), .nts_ram_din(nts_ram_din), .nts_ram_dout(ram_dout),
        .depth(depth), .ovf_err(ovf_err), .unf_err(unf_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    assign rf_rd_data = rf[rf_rd_idx];

    // Single-port RAM with one-cycle read latency
    always @(posedge clk) begin
        if (nts_ram_cs) begin
            if (nts_ram_we) mem[nts_ram_addr] <= nts_ram_din;
            else            ram_dout <= mem[nts_ram_addr];
        end
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] all_outs();
        return {busy, done, nts_ram_cs, nts_ram_we, nts_ram_wem, nts_ram_addr, nts_ram_din,
                rf_wr_en, rf_wr_idx, rf_wr_data, rf_rd_idx};
    endfunction

    function automatic logic [127:0] exp_depth();
        return 128'(stack_q.size() / NREGS);
    endfunction

    task automatic check_flags(input string tag);
        check({tag, "_flags"}, {ovf_err, unf_err}, {ERR_EN & exp_ovf, ERR_EN & exp_unf});
    endtask

    task automatic fill_rand();
        for (int i = 0; i < NREGS; i++) rf[i] = $urandom;
    endtask

    // Entered in cycle 1 after the save request was sampled
    task automatic run_save_body(input string tag);
        int base;
        if (stack_q.size() == NFR * NREGS) begin
            exp_ovf = 1'b1;
            check({tag, "_ovf_idle"}, all_outs(), 128'd0);
            check_flags(tag);
            check({tag, "_ovf_depth"}, depth, 128'(NFR));
        end else begin
            base = (stack_q.size() / NREGS) * NREGS;
            for (int k = 0; k < NREGS; k++) begin
                check(tag, {busy, nts_ram_cs, nts_ram_we, nts_ram_wem, nts_ram_addr, nts_ram_din,
                            done, rf_rd_idx, rf_wr_en},
                           {1'b1, 1'b1, 1'b1, 4'hF, 8'(base + k), rf[k],
                            (k == NREGS - 1), 4'(k), 1'b0});
                if (k < NREGS - 1) tick();
            end
            for (int k = 0; k < NREGS; k++) stack_q.push_back(rf[k]);
            tick();
            check({tag, "_end"}, {busy, done, nts_ram_cs}, 3'b000);
            check({tag, "_depth"}, depth, exp_depth());
        end
    endtask

    // Entered in cycle 1 after the restore request was sampled; ends in the done cycle
    task automatic run_restore_body(input string tag, input int pend_at);
        int fr;
        bit rd, wb;
        logic [DW-1:0] wd;
        logic [AW-1:0] ad;
        logic [IW-1:0] wi;
        if (stack_q.size() == 0) begin
            exp_unf = 1'b1;
            check({tag, "_unf_idle"}, all_outs(), 128'd0);
            check_flags(tag);
            check({tag, "_unf_depth"}, depth, 128'd0);
        end else begin
            fr = stack_q.size() / NREGS - 1;
            for (int c = 1; c <= NREGS + 1; c++) begin
                rd = (c <= NREGS);
                wb = (c >= 2);
                ad = rd ? 8'(fr * NREGS + c - 1) : 8'h00;
                wi = wb ? 4'(c - 2) : 4'h0;
                wd = 32'h0;
                if (wb) wd = stack_q[fr * NREGS + c - 2];
                check(tag, {busy, nts_ram_cs, nts_ram_we, nts_ram_wem, nts_ram_addr, done,
                            rf_wr_en, rf_wr_idx, rf_wr_data},
                           {1'b1, rd, 1'b0, 4'h0, ad, (c == NREGS + 1), wb, wi, wd});
                check({tag, "_depth"}, depth, 128'(fr));
                if (wb) rf[c - 2] = wd;
                if (c == pend_at) save_req = 1'b1;
                if (c <= NREGS) begin
                    tick();
                    save_req = 1'b0;
                end
            end
            for (int k = 0; k < NREGS; k++) void'(stack_q.pop_back());
        end
    endtask

    task automatic do_save(input string tag);
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        run_save_body(tag);
    endtask

    task automatic do_restore(input string tag);
        bit was_empty;
        was_empty = (stack_q.size() == 0);
        restore_req = 1'b1;
        tick();
        restore_req = 1'b0;
        run_restore_body(tag, 0);
        if (!was_empty) begin
            tick();
            check({tag, "_end"}, {busy, done, nts_ram_cs, rf_wr_en}, 4'b0000);
            check({tag, "_end_depth"}, depth, exp_depth());
        end
    endtask

    initial begin
        for (int i = 0; i < NREGS; i++) rf[i] = 32'h0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;

        repeat (3) tick();
        check("reset_outs", all_outs(), 128'd0);
        check("reset_depth", depth, 128'd0);
        check_flags("reset");
        rst = 1'b0;
        tick();

        // Single save of a recognisable pattern, then restore into a cleared regfile
        for (int i = 0; i < NREGS; i++) rf[i] = 32'hA000_0000 + 32'(i);
        do_save("save1");
        for (int i = 0; i < NREGS; i++) rf[i] = 32'h0;
        do_restore("restore1");

        // Nested frames come back in LIFO order
        fill_rand();
        do_save("nest_s0");
        fill_rand();
        do_save("nest_s1");
        do_restore("nest_r1");
        do_restore("nest_r0");

        // Underflow, then clear
        do_restore("unf");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        check_flags("clr_unf");

        // Fill the stack, overflow on the 17th save
        for (int n = 0; n < NFR; n++) begin
            fill_rand();
            do_save("fill");
        end
        do_save("ovf17");

        // A new overflow in the same cycle as err_clr keeps the flag set
        save_req = 1'b1;
        err_clr  = 1'b1;
        tick();
        save_req = 1'b0;
        err_clr  = 1'b0;
        exp_unf  = 1'b0;
        run_save_body("ovf_setwins");
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        check_flags("clr_ovf");

        for (int n = 0; n < NFR; n++) do_restore("drain");

        // Simultaneous save and restore in IDLE: save runs, restore dropped
        fill_rand();
        save_req    = 1'b1;
        restore_req = 1'b1;
        tick();
        save_req    = 1'b0;
        restore_req = 1'b0;
        run_save_body("collide");

        // Save requested during restore cycle 5 starts right after the restore's done
        restore_req = 1'b1;
        tick();
        restore_req = 1'b0;
        run_restore_body("pend_r", 5);
        tick();
        run_save_body("pend_s");

        // Reset in save cycle 8 abandons the frame and the stack
        fill_rand();
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
        repeat (7) tick();
        check("rst_pre", {nts_ram_cs, nts_ram_addr}, {1'b1, 8'(NREGS + 7)});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        stack_q.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        check("rst_outs", all_outs(), 128'd0);
        check("rst_depth", depth, 128'd0);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("rst_no_done", {busy, done, nts_ram_cs}, 3'b000);
        end

        // Random mix of saves, restores and idle gaps
        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 2) != 0) begin
                fill_rand();
                do_save("rnd_save");
            end else begin
                do_restore("rnd_restore");
            end
            repeat ($urandom_range(0, 2)) tick();
            check("rnd_depth", depth, exp_depth());
            check_flags("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/e203_nts_ctx_seq.md
# e203_nts_ctx_seq

Context save/restore sequencer that drives the NTS RAM port of the SRAM wrapper (`nts_ram_*`). On an interrupt register-save request it streams NREGS register values from the core regfile into the next free stack frame. On an mret restore request it reads the top frame back and writes each register into the regfile. It sits directly upstream of the NTS RAM and beside the regfile, and keeps a frame pointer so that nested interrupts stack.

## Interface
Parameters:
- NREGS, 16: registers per frame; power of two, ≥2.
- AW, 8: NTS RAM address width (`E203_NTS_RAM_AW`).
- DW, 32: data width (`E203_NTS_RAM_DW`).
- MW, 4: write-mask width (`E203_NTS_RAM_MW`).

Ports:
- clk  in  1  core clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- save_req  in  1  one-cycle pulse; start context save (from irq_regsave).
- restore_req  in  1  one-cycle pulse; start context restore (from mret2ram).
- busy  out  1  sequencer not IDLE.
- done  out  1  one-cycle pulse at end of a save or restore.
- rf_rd_idx  out  log2(NREGS)  regfile read index.
- rf_rd_data  in  DW  regfile read data; combinational from rf_rd_idx.
- rf_wr_en  out  1  regfile write strobe.
- rf_wr_idx  out  log2(NREGS)  regfile write index.
- rf_wr_data  out  DW  regfile write data.
- nts_ram_cs  out  1  RAM chip select.
- nts_ram_we  out  1  RAM write enable.
- nts_ram_addr  out  AW  RAM word address.
- nts_ram_wem  out  MW  RAM write mask; all ones on writes, zero on reads.
- nts_ram_din  out  DW  RAM write data.
- nts_ram_dout  in  DW  RAM read data; valid 1 cycle after a read with cs=1.
- depth  out  AW-log2(NREGS)+1  number of frames currently stacked.
- ovf_err, unf_err  out  1  sticky overflow and underflow flags.
- err_clr  in  1  clears both error flags.

## Operation
- NFRAMES = 2^AW / NREGS. The frame pointer fp equals depth. Frame f occupies addresses {f, idx}.
- States:
  - IDLE
  - SAVE: idx 0..NREGS-1
  - RD: idx 0..NREGS-1, issues reads
  - WB: the final write-back cycle
- IDLE accepts save_req or restore_req. If both arrive in the same cycle, save wins and restore_req is dropped.
- SAVE: each cycle it drives rf_rd_idx=idx, cs=we=1, addr={fp,idx}, din=rf_rd_data. After idx=NREGS-1: fp+=1, done pulses, and the state returns to IDLE.
- Restore: fp-=1 on acceptance. The state is RD with idx from 0. Each RD cycle drives cs=1, we=0, addr={fp,idx}.
  - The following cycle drives rf_wr_en=1, rf_wr_idx=idx_prev, rf_wr_data=nts_ram_dout.
  - After the last read the state is WB, which performs the final write-back, then done pulses and the state returns to IDLE.
- save_req during RD/WB is latched in a one-deep pending flag. The save starts in the cycle after done.
  - A save_req during SAVE is dropped.
  - A restore_req while busy is dropped.
- Save with fp==NFRAMES: not started, ovf_err set, no RAM access.
- Restore with fp==0: not started, unf_err set.
- When err_clr and a new error occur in the same cycle, the set wins.
- Outputs not named in the current state are 0. The cs, we and rf_wr_en outputs are registered-state decodes with no glitch paths.

## Timing
- Reset values:
  - state=IDLE, fp=0, pending=0.
  - All outputs 0, including busy, done, cs, we, wem, addr, din, rf_wr_* and the error flags.
- Save latency: request accepted at cycle 0. Writes occupy cycles 1..NREGS. done is asserted in cycle NREGS, co-cycle with the last write.
- Restore latency: reads occupy cycles 1..NREGS. Write-backs occupy cycles 2..NREGS+1. done is asserted in cycle NREGS+1.
- rst asserted mid-sequence aborts the sequence. fp returns to 0, partially saved frames are abandoned, and no done is issued.
- depth updates in the cycle after the save completes or the restore is accepted.

## Configuration
- E203_NTS_CTX_ERR_EN defined: ovf_err and unf_err are sticky as above, and err_clr is honoured.
- E203_NTS_CTX_ERR_EN undefined:
  - Error registers are removed; ovf_err and unf_err are tied to 0 and err_clr is ignored.
  - Overflow and underflow requests are still silently dropped.

## Structure
- Shared package `e203_nts_ctx_pkg`:
  - state enum (IDLE, SAVE, RD, WB).
  - NFRAMES and index/fp width localparams derived from NREGS and AW.
- Single module. An optional sub-module `e203_nts_ctx_fp` holds fp, overflow/underflow detection and the error flags.

## Test plan
- Single save: NREGS=16, rf[i]=0xA000_0000+i, save_req pulse.
  - Expect 16 writes at addr 0x00..0x0F with the matching data and wem=4'hF.
  - done is asserted in cycle 16 and depth=1.
- Save then restore: clear the regfile, then pulse restore_req.
  - Expect rf_wr of idx 0..15 with the original values in cycles 2..17, done in cycle 17, and depth=0.
- Nesting: two saves with different data, then two restores.
  - The second frame is at addr 0x10..0x1F.
  - Restores return the frame-1 data first, then the frame-0 data.
- Overflow/underflow: restore at depth 0 sets unf_err with no cs. 17 saves: the 17th sets ovf_err and depth stays 16. err_clr clears both.
- Collisions:
  - save_req and restore_req in the same IDLE cycle: the save runs and the restore is dropped.
  - save_req during restore cycle 5: the save starts one cycle after restore done.
- Reset at save cycle 8: all outputs 0 the next cycle, depth=0, and no done.
